// File: rtl/shared_reg_arb_pkg.sv
// Shared definitions for the shared_reg_arb block: arbiter state encoding
// and the helper that sizes requester id fields.
package shared_reg_arb_pkg;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  // Width of a requester id; never narrower than one bit.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/shared_reg_arb_rr_pick.sv
// Combinational round-robin picker: grants the first asserted request at or
// after i_ptr, wrapping from NREQ-1 back to 0. Returns one-hot and binary forms.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [IDW-1:0]  o_idx
);

  logic [IDW-1:0] w_j;
  logic           w_found;

  // Scan NREQ positions starting at the pointer; the first hit wins.
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_j     = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_j = IDW'((int'(i_ptr) + k) % NREQ);
      if (!w_found && i_req[w_j]) begin
        o_gnt[w_j] = 1'b1;
        o_idx      = w_j;
        w_found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shared_reg_arb.sv
// shared_reg_arb: round-robin arbitration of NREQ requesters onto a single
// WIDTH-bit register. Each granted transaction reads or writes the register
// and produces a registered one-cycle response tagged with the requester id.
// Optional feature macro SHARED_REG_ARB_LOCK_EN adds req_lock, the LOCKED
// state and the LOCK_MAX idle timeout; without it locked is tied low.
module shared_reg_arb
  import shared_reg_arb_pkg::*;
#(
  parameter int               NREQ      = 4,
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               LOCK_MAX  = 8
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ-1:0]           req_we,
  input  logic [NREQ*WIDTH-1:0]     req_wdata,
`ifdef SHARED_REG_ARB_LOCK_EN
  input  logic [NREQ-1:0]           req_lock,
`endif
  output logic [NREQ-1:0]           req_ready,
  output logic                      rsp_valid,
  output logic [id_w(NREQ)-1:0]     rsp_id,
  output logic [WIDTH-1:0]          rsp_data,
  output logic [WIDTH-1:0]          reg_q,
  output logic                      locked
);

  localparam int IDW = id_w(NREQ);

  if (NREQ < 2 || NREQ > 16 || LOCK_MAX < 1) begin : g_bad_param
    $error("shared_reg_arb: NREQ must be 2..16 and LOCK_MAX >= 1");
  end

  logic [WIDTH-1:0] w_wdata [NREQ];
  logic [NREQ-1:0]  w_pick_req;
  logic [IDW-1:0]   w_pick_ptr;
  logic [NREQ-1:0]  w_gnt;
  logic [IDW-1:0]   w_idx;
  logic             w_hs;
  logic [WIDTH-1:0] w_newval;
  logic [IDW-1:0]   w_ptr_nxt;

  logic [IDW-1:0]   r_ptr;
  logic [WIDTH-1:0] r_reg;
  logic             r_rsp_valid;
  logic [IDW-1:0]   r_rsp_id;
  logic [WIDTH-1:0] r_rsp_data;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign w_wdata[g] = req_wdata[g*WIDTH +: WIDTH];
  end

`ifdef SHARED_REG_ARB_LOCK_EN
  localparam int CW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;

  state_e         r_state, w_state_nxt;
  logic [IDW-1:0] r_owner, w_owner_nxt;
  logic [CW-1:0]  r_cnt,   w_cnt_nxt;

  // While locked, only the owner's request reaches the picker.
  always_comb begin
    w_pick_req = req_valid;
    w_pick_ptr = r_ptr;
    if (r_state == ST_LOCKED) begin
      w_pick_req          = '0;
      w_pick_req[r_owner] = req_valid[r_owner];
      w_pick_ptr          = r_owner;
    end
  end

  // Lock FSM state, owner and idle counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_owner <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Lock entry on a locking handshake, release on an unlocking owner
  // handshake or after LOCK_MAX idle cycles.
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_hs && req_lock[w_idx]) begin
          w_state_nxt = ST_LOCKED;
          w_owner_nxt = w_idx;
          w_cnt_nxt   = '0;
        end
      end
      ST_LOCKED: begin
        if (w_hs) begin
          w_cnt_nxt = '0;
          if (!req_lock[w_idx]) w_state_nxt = ST_IDLE;
        end else if (r_cnt == CW'(LOCK_MAX - 1)) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign locked = (r_state == ST_LOCKED);
`else
  assign w_pick_req = req_valid;
  assign w_pick_ptr = r_ptr;
  assign locked     = 1'b0;
`endif

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .i_req (w_pick_req),
    .i_ptr (w_pick_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx)
  );

  assign req_ready = w_gnt;
  assign w_hs      = |w_gnt;
  assign w_newval  = req_we[w_idx] ? w_wdata[w_idx] : r_reg;
  assign w_ptr_nxt = (w_idx == IDW'(NREQ - 1)) ? '0 : w_idx + 1'b1;

  // Shared register and round-robin pointer update on each handshake.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_reg <= RESET_VAL;
      r_ptr <= '0;
    end else if (w_hs) begin
      r_reg <= w_newval;
      r_ptr <= w_ptr_nxt;
    end
  end

  // One-cycle response carrying the id and the post-transaction value.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
    end else begin
      r_rsp_valid <= w_hs;
      if (w_hs) begin
        r_rsp_id   <= w_idx;
        r_rsp_data <= w_newval;
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign reg_q     = r_reg;

endmodule

// File: tb/tb_shared_reg_arb.sv
// Bench for shared_reg_arb: directed scenarios plus randomized traffic,
// checked against a transaction-level model with a response scoreboard.
module tb_shared_reg_arb;

  localparam int               NREQ     = 4;
  localparam int               WIDTH    = 8;
  localparam int               IDW      = 2;
  localparam int               LOCK_MAX = 8;
  localparam logic [WIDTH-1:0] RST_V    = 8'h3C;

  logic                  clk = 1'b0;
  logic                  rstn = 1'b0;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_we = '0;
  logic [NREQ*WIDTH-1:0] req_wdata = '0;
`ifdef SHARED_REG_ARB_LOCK_EN
  logic [NREQ-1:0]       req_lock = '0;
`endif
  logic [NREQ-1:0]       req_ready;
  logic                  rsp_valid;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_data;
  logic [WIDTH-1:0]      reg_q;
  logic                  locked;

  always #5 clk = ~clk;

  shared_reg_arb #(
    .NREQ      (NREQ),
    .WIDTH     (WIDTH),
    .RESET_VAL (RST_V),
    .LOCK_MAX  (LOCK_MAX)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_wdata (req_wdata),
`ifdef SHARED_REG_ARB_LOCK_EN
    .req_lock  (req_lock),
`endif
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .reg_q     (reg_q),
    .locked    (locked)
  );

  typedef struct {
    int               id;
    logic [WIDTH-1:0] data;
    int               due;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;

  // Requester-side intent: pending requests held until granted.
  bit               d_valid [NREQ];
  bit               d_we    [NREQ];
  logic [WIDTH-1:0] d_wdata [NREQ];
  bit               d_lock  [NREQ];

  // Transaction-level reference state.
  logic [WIDTH-1:0] m_reg;
  int               m_ptr;
  bit               m_locked;
  int               m_owner;
  int               m_cnt;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_reg = RST_V; m_ptr = 0; m_locked = 0; m_owner = 0; m_cnt = 0;
    for (int i = 0; i < NREQ; i++) begin
      d_valid[i] = 0; d_we[i] = 0; d_wdata[i] = '0; d_lock[i] = 0;
    end
  endtask

  // One clock: drive the requesters, check the grant, advance the model.
  task automatic step();
    int               g;
    logic [NREQ-1:0]  exp_rdy;
    @(posedge clk); #1;
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i] = d_valid[i];
      req_we[i]    = d_we[i];
      req_wdata[i*WIDTH +: WIDTH] = d_wdata[i];
`ifdef SHARED_REG_ARB_LOCK_EN
      req_lock[i]  = d_lock[i];
`endif
    end
    @(negedge clk);
    g = -1;
    for (int k = 0; k < NREQ; k++) begin
      int j = (m_ptr + k) % NREQ;
      if (g < 0 && d_valid[j] && (!m_locked || j == m_owner)) g = j;
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check("req_ready", req_ready, exp_rdy);
    check("reg_q", reg_q, m_reg);
    check("locked", locked, m_locked);
    if (g >= 0) begin
      if (d_we[g]) m_reg = d_wdata[g];
      sb.push_back('{id: g, data: m_reg, due: cyc + 1});
      m_ptr = (g + 1) % NREQ;
      if (m_locked) begin
        m_locked = d_lock[g]; m_cnt = 0;
      end else if (d_lock[g]) begin
        m_locked = 1; m_owner = g; m_cnt = 0;
      end
      d_valid[g] = 0;
    end else if (m_locked) begin
      if (m_cnt == LOCK_MAX - 1) begin
        m_locked = 0; m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end
  endtask

  // Asynchronous reset pulse, checked before any clock edge passes.
  task automatic do_reset(input string tag);
    @(posedge clk); #1;
    rstn = 1'b0;
    req_valid = '0; req_we = '0; req_wdata = '0;
`ifdef SHARED_REG_ARB_LOCK_EN
    req_lock = '0;
`endif
    #1;
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_reg_q"}, reg_q, RST_V);
    check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_locked"}, locked, 0);
    sb.delete();
    model_reset();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic req(input int i, input bit we, input logic [WIDTH-1:0] d, input bit lk);
    d_valid[i] = 1; d_we[i] = we; d_wdata[i] = d; d_lock[i] = lk;
  endtask

  // Response monitor: every cycle out of reset, rsp must match the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (sb.size() > 0 && sb[0].due <= cyc) begin
          e = sb.pop_front();
          n_cmp++;
          if (rsp_valid !== 1'b1 || rsp_id !== IDW'(e.id) || rsp_data !== e.data) begin
            n_fail++;
            $display("FAIL rsp: got valid=%0b id=%0d data=%0h, expected valid=1 id=%0d data=%0h (cycle %0d)",
                     rsp_valid, rsp_id, rsp_data, e.id, e.data, cyc);
          end
        end else begin
          n_cmp++;
          if (rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rsp_idle: got valid=%0b id=%0d data=%0h, expected valid=0 (cycle %0d)",
                     rsp_valid, rsp_id, rsp_data, cyc);
          end
        end
      end
    end
  end

  initial begin
    model_reset();
    #12;
    check("init_rsp_valid", rsp_valid, 0);
    check("init_reg_q", reg_q, RST_V);
    check("init_req_ready", req_ready, 0);
    check("init_locked", locked, 0);
    @(posedge clk); #1 rstn = 1'b1;

    // Single write from requester 0, response next cycle.
    req(0, 1, 8'hA5, 0); step();
    step();

    // Write 0x11, then requester 2 reads it back.
    req(3, 1, 8'h11, 0); step();
    req(2, 0, 8'h00, 0); step();
    step();

    // Reset while a response is in flight.
    req(1, 1, 8'h77, 0); step();
    do_reset("rst_rsp");

    // All four requesters continuously valid from ptr 0.
    for (int c = 0; c < 5; c++) begin
      for (int i = 0; i < NREQ; i++)
        if (!d_valid[i]) req(i, 1, WIDTH'($urandom), 0);
      step();
    end
    for (int i = 0; i < NREQ; i++) d_valid[i] = 0;
    step();

`ifdef SHARED_REG_ARB_LOCK_EN
    // Lock held across repeated owner transactions, others wait.
    do_reset("rst_lk1");
    req(0, 0, 8'h00, 0); step();
    req(0, 1, 8'h01, 0); req(1, 1, 8'h5A, 1); req(2, 1, 8'h02, 0); step();
    req(1, 0, 8'h00, 1); step();
    step();
    req(1, 1, 8'h6B, 0); step();
    repeat (3) step();

    // Lock owner goes silent: forced release after LOCK_MAX idle cycles.
    do_reset("rst_lk2");
    req(0, 0, 8'h00, 0); step();
    req(1, 1, 8'h33, 1); step();
    req(2, 1, 8'h44, 0);
    repeat (11) step();

    // Reset while locked: next grant from requester 0.
    req(3, 1, 8'h55, 1); step();
    do_reset("rst_lk3");
    for (int i = 0; i < NREQ; i++) req(i, 0, 8'h00, 0);
    step();
    for (int i = 0; i < NREQ; i++) d_valid[i] = 0;
    step();
`endif

    // Randomized traffic with occasional withdrawals.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!d_valid[i]) begin
          if ($urandom_range(2) == 0) begin
            req(i, bit'($urandom_range(1)), WIDTH'($urandom), 0);
`ifdef SHARED_REG_ARB_LOCK_EN
            d_lock[i] = ($urandom_range(3) == 0);
`endif
          end
        end else if ($urandom_range(15) == 0) begin
          d_valid[i] = 0;
        end
      end
      step();
    end

    // Drain the last responses.
    for (int i = 0; i < NREQ; i++) d_valid[i] = 0;
    repeat (3) step();
    check("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/shared_reg_arb.md
# shared_reg_arb

Round-robin arbiter sharing one WIDTH-bit register among NREQ requesters through a valid/ready handshake. Each granted transaction either writes the register or reads it, and returns a one-cycle response tagged with the requester id. An optional lock lets one requester own the register for atomic read-modify-write sequences. The block sits between the requester ports and the shared flop storage; the register lives inside this block.

## Interface
- NREQ, 4, number of requesters (2..16)
- WIDTH, 8, register width
- RESET_VAL, 0, register value after reset
- LOCK_MAX, 8, idle cycles before a held lock is forcibly released (only with lock feature)
- clk  in  1  clock, rising edge
- rstn  in  1  reset, asynchronous, active-low
- req_valid  in  NREQ  per-requester request
- req_we  in  NREQ  1 = write, 0 = read
- req_wdata  in  NREQ*WIDTH  write data, requester i at bits [i*WIDTH +: WIDTH]
- req_lock  in  NREQ  request or keep the lock (lock feature only)
- req_ready  out  NREQ  one-hot grant; a transaction completes when valid & ready
- rsp_valid  out  1  response strobe
- rsp_id  out  $clog2(NREQ)  requester served
- rsp_data  out  WIDTH  register value after the transaction
- reg_q  out  WIDTH  current register contents
- locked  out  1  lock held (constant 0 without the lock feature)

## Operation
- States: IDLE, LOCKED. LOCKED exists only with the lock feature.
- IDLE: the arbiter picks the first req_valid at or after rr_ptr, wrapping NREQ-1 -> 0. It drives req_ready for that requester only. No valid requests means req_ready = 0.
- Handshake (idx i): write sets reg_q <= wdata[i]; read leaves reg_q unchanged. rr_ptr <= (i+1) mod NREQ.
- Requesters hold valid/we/wdata/lock stable until ready. Dropping valid before ready is legal; the request is withdrawn.
- At most one transaction per cycle.
- A handshake with req_lock[i]=1 in IDLE enters LOCKED with owner=i and clears lock_cnt.
- LOCKED: only the owner can be granted. An owner handshake with req_lock=0 returns to IDLE; with req_lock=1 it stays LOCKED and clears lock_cnt.
- Each LOCKED cycle without an owner handshake increments lock_cnt. When lock_cnt reaches LOCK_MAX-1 on a cycle with no handshake, the block forces IDLE.
- rr_ptr does not advance while LOCKED except on an owner handshake, where it becomes owner+1.
- Reset values: reg_q=RESET_VAL, rsp_valid=0, rsp_id=0, rsp_data=0, state=IDLE, rr_ptr=0, lock_cnt=0, locked=0. req_ready is 0 because it is combinational from req_valid and state.

## Timing
- req_ready is combinational from req_valid, rr_ptr, state and owner: zero-cycle grant.
- reg_q updates on the handshake edge.
- rsp_valid, rsp_id and rsp_data are registered and appear exactly 1 cycle after the handshake, for 1 cycle. rsp_data equals the post-write value.
- Back-to-back handshakes give back-to-back responses; there is no bubble.
- Reset asserted mid-lock or mid-response clears everything immediately; the response in flight is lost.

## Configuration
- SHARED_REG_ARB_LOCK_EN defined: the req_lock port, LOCKED state, owner, lock_cnt and LOCK_MAX timeout are present; locked reflects state.
- Macro undefined: the req_lock port is absent, the FSM stays in IDLE, locked is tied 0, and LOCK_MAX is ignored.

## Structure
- Package shared_reg_arb_pkg holds the state enum (ST_IDLE, ST_LOCKED) and a localparam helper for id width.
- Sub-module rr_pick: combinational round-robin picker. Inputs are the request vector and pointer. Outputs are a one-hot grant and a binary index. It is reused for the owner-masked request vector in LOCKED.

## Test plan
- Reset with RESET_VAL=0x3C -> reg_q=0x3C, rsp_valid=0, req_ready=0, locked=0.
- req0 write 0xA5 -> req_ready=0001 the same cycle; next cycle reg_q=0xA5, rsp_valid=1, rsp_id=0, rsp_data=0xA5.
- All four requesters valid continuously, ptr=0 -> grants 0,1,2,3,0 on consecutive cycles with no idle cycle.
- reg_q=0x11, req2 read -> rsp_id=2, rsp_data=0x11, reg_q unchanged.
- Lock: req1 writes with lock=1 while req0/req2 are waiting -> only req1 is granted until it handshakes with lock=0. In a separate run, req1 goes silent after taking the lock -> locked drops after 8 cycles (LOCK_MAX=8), then req2 is granted.
- rstn pulsed low while LOCKED with a response pending -> immediate IDLE, locked=0, rsp_valid=0, reg_q=RESET_VAL, next grant starts from req0.
